// File: rtl/rbcp_axil_pkg.sv
// Shared types and helpers for the RBCP to AXI4-Lite bridge.
//   state_t       : bridge FSM states
//   AXI_RESP_OKAY : the only response code treated as success
//   lane_select   : pick byte lane 'lane' out of a 32-bit word
//   lane_strb     : one-hot write strobe for byte lane 'lane'
package rbcp_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_ACK
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [7:0] lane_select(input logic [31:0] data, input logic [1:0] lane);
    return data[8*lane +: 8];
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/rbcp_axil_bridge.sv
// Converts SiTCP RBCP single-byte accesses into one AXI4-Lite master
// transaction each, with at most one transaction outstanding.
//   clk, rst          : clock, asynchronous active-high reset
//   rbcp_*            : RBCP slave side (1-cycle we/re strobes, 1-cycle ack)
//   m_axi_*           : AXI4-Lite master, 32-bit address/data
//   err_clr           : clears the sticky error flags
//   err_drop          : strobe ignored because the bridge was busy (or we+re together)
//   err_timeout       : a response took TIMEOUT_CYCLES or more; its ack is suppressed
//   err_resp          : a non-OKAY bresp/rresp was seen
//   busy              : FSM is not idle
module rbcp_axil_bridge
  import rbcp_axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rbcp_act,
  input  logic [31:0] rbcp_addr,
  input  logic        rbcp_we,
  input  logic [7:0]  rbcp_wd,
  input  logic        rbcp_re,
  output logic [7:0]  rbcp_rd,
  output logic        rbcp_ack,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic        err_clr,
  output logic        err_drop,
  output logic        err_timeout,
  output logic        err_resp,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYCLES - 1);

  state_t         state, state_n;
  logic [31:0]    addr_q, wdata_q;
  logic [3:0]     strb_q;
  logic [7:0]     rd_q;
  logic           aw_done, w_done;
  logic [CW-1:0]  cnt;
  logic           in_resp, timed_out;
  logic           aw_hs, w_hs, b_hs, r_hs;
  logic           drop_evt, resp_evt, tmo_evt;

  // rbcp_act is informational only; strobes are honoured regardless.
  logic unused_act;
  assign unused_act = rbcp_act;

  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign in_resp   = (state == ST_WR_RESP) || (state == ST_RD_RESP);
  assign timed_out = (cnt == CNT_MAX);

  assign m_axi_awaddr = {addr_q[31:2], 2'b00};
  assign m_axi_araddr = {addr_q[31:2], 2'b00};
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = strb_q;
  assign rbcp_rd      = rd_q;
  assign busy         = (state != ST_IDLE);

  // In IDLE only a simultaneous we+re is a drop (write wins); elsewhere any strobe is.
  assign drop_evt = (state == ST_IDLE) ? (rbcp_we & rbcp_re) : (rbcp_we | rbcp_re);
  assign resp_evt = (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) ||
                    (r_hs && (m_axi_rresp != AXI_RESP_OKAY));
  // Fires on the cycle the counter steps onto its limit without a response.
  assign tmo_evt  = in_resp && (cnt == CNT_PRE) && (state_n == state);

  always_comb begin
    state_n       = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rbcp_ack      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rbcp_we)      state_n = ST_WR_REQ;
        else if (rbcp_re) state_n = ST_RD_REQ;
      end
      ST_WR_REQ: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~w_done;
        // Each channel is finished once done earlier or handshaking now.
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_n = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = timed_out ? ST_IDLE : ST_ACK;
      end
      ST_RD_REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_n = timed_out ? ST_IDLE : ST_ACK;
      end
      ST_ACK: begin
        rbcp_ack = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rd_q        <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
      err_resp    <= 1'b0;
    end else begin
      state <= state_n;

      if (state == ST_IDLE && rbcp_we) begin
        addr_q  <= rbcp_addr;
        wdata_q <= {4{rbcp_wd}};
        strb_q  <= lane_strb(rbcp_addr[1:0]);
      end else if (state == ST_IDLE && rbcp_re) begin
        addr_q  <= rbcp_addr;
      end

      if (state == ST_WR_REQ) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      if (r_hs) rd_q <= lane_select(m_axi_rdata, addr_q[1:0]);

      if (state_n != state)          cnt <= '0;
      else if (in_resp && !timed_out) cnt <= cnt + 1'b1;

      // Set events beat a same-cycle clear.
      err_drop    <= drop_evt | (err_drop    & ~err_clr);
      err_timeout <= tmo_evt  | (err_timeout & ~err_clr);
      err_resp    <= resp_evt | (err_resp    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_rbcp_axil_bridge.sv
// Directed bench for rbcp_axil_bridge: a delay-programmable AXI4-Lite slave,
// an op-level model of what each RBCP access must produce, and a negedge
// compare process checking every visible request/ack against that model.
module tb_rbcp_axil_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rbcp_act = 1'b1;
  logic [31:0] rbcp_addr = '0;
  logic        rbcp_we = 1'b0, rbcp_re = 1'b0;
  logic [7:0]  rbcp_wd = '0;
  logic [7:0]  rbcp_rd;
  logic        rbcp_ack;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        err_clr = 1'b0;
  logic        err_drop, err_timeout, err_resp, busy;

  always #5 clk = ~clk;

  rbcp_axil_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr),
    .rbcp_we(rbcp_we), .rbcp_wd(rbcp_wd), .rbcp_re(rbcp_re), .rbcp_rd(rbcp_rd),
    .rbcp_ack(rbcp_ack),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_clr(err_clr), .err_drop(err_drop), .err_timeout(err_timeout),
    .err_resp(err_resp), .busy(busy)
  );

  // ---------------- slave: each channel waits *_dly cycles ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_n, w_n, ar_n;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic        aw_hs, w_hs, ar_hs, aw_now, w_now;

  assign m_axi_awready = (aw_wait >= aw_dly);
  assign m_axi_wready  = (w_wait >= w_dly);
  assign m_axi_arready = (ar_wait >= ar_dly);
  assign m_axi_bvalid  = b_pend && (b_wait >= b_dly);
  assign m_axi_rvalid  = r_pend && (r_wait >= r_dly);
  assign m_axi_bresp   = s_bresp;
  assign m_axi_rresp   = s_rresp;
  assign m_axi_rdata   = s_rdata;
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign aw_now = aw_got | aw_hs;
  assign w_now  = w_got | w_hs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin aw_n <= aw_n + 1; last_awaddr <= m_axi_awaddr; end
      if (w_hs)  begin w_n <= w_n + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb; end
      if (ar_hs) begin ar_n <= ar_n + 1; last_araddr <= m_axi_araddr; end
      if (b_pend) begin
        if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
        else b_wait <= b_wait + 1;
      end
      if (aw_now && w_now) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (ar_hs) begin
        r_pend <= 1'b1; r_wait <= 0;
      end else if (r_pend) begin
        if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;
        else r_wait <= r_wait + 1;
      end
    end
  end

  initial begin aw_n = 0; w_n = 0; ar_n = 0; end

  // ---------------- model of the current RBCP op ----------------
  int          vec = 0, errs = 0;
  logic        op_wr = 1'b0, exp_ack = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_strb = '0;
  logic [7:0]  exp_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int         cyc = 0, aw_cyc = 0, w_cyc = 0, ack_cnt = 0, ack_at = 0;
  logic [7:0] last_rd = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (m_axi_awvalid) begin
        aw_cyc <= aw_cyc + 1;
        chk("awaddr", m_axi_awaddr, exp_addr);
        chk("awprot", m_axi_awprot, 0);
      end
      if (m_axi_wvalid) begin
        w_cyc <= w_cyc + 1;
        chk("wdata", m_axi_wdata, exp_wdata);
        chk("wstrb", m_axi_wstrb, exp_strb);
      end
      if (m_axi_arvalid) begin
        chk("araddr", m_axi_araddr, exp_addr);
        chk("arprot", m_axi_arprot, 0);
      end
      if (rbcp_ack) begin
        ack_cnt <= ack_cnt + 1;
        ack_at  <= cyc + 1;
        last_rd <= rbcp_rd;
        chk("ack_allowed", rbcp_ack, exp_ack);
        if (!op_wr) chk("rbcp_rd", rbcp_rd, exp_rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int t0, b_ack, b_aw, b_awc, b_wc;

  task automatic snap();
    t0 = cyc; b_ack = ack_cnt; b_aw = aw_n; b_awc = aw_cyc; b_wc = w_cyc;
  endtask

  // Write strobe; optionally re at the same time, or a second we one cycle later.
  task automatic start_wr(input logic [31:0] a, input logic [7:0] d, input bit with_re,
                          input bit dbl, input logic [31:0] a2, input logic [7:0] d2);
    @(negedge clk); #1;
    rbcp_addr = a; rbcp_wd = d; rbcp_we = 1'b1; rbcp_re = with_re;
    op_wr = 1'b1; exp_addr = a & ~32'h3; exp_wdata = {4{d}};
    exp_strb = 4'(1 << (a % 4)); exp_ack = (b_dly < TO);
    snap();
    @(negedge clk); #1;
    rbcp_re = 1'b0;
    if (dbl) begin
      rbcp_addr = a2; rbcp_wd = d2;
      @(negedge clk); #1;
    end
    rbcp_we = 1'b0;
  endtask

  task automatic start_rd(input logic [31:0] a);
    @(negedge clk); #1;
    rbcp_addr = a; rbcp_re = 1'b1;
    op_wr = 1'b0; exp_addr = a & ~32'h3;
    exp_rd = 8'((s_rdata >> (8 * (a % 4))) & 32'hFF); exp_ack = (r_dly < TO);
    snap();
    @(negedge clk); #1;
    rbcp_re = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); #1; n++; end
    if (busy) chk("idle_timeout", busy, 0);
    @(negedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); #1; err_clr = 1'b1;
    @(negedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_ack_busy", {rbcp_ack, busy}, 0);
    chk("rst_errs", {err_drop, err_timeout, err_resp}, 0);
    chk("rst_data", {rbcp_rd, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    rst = 1'b0;

    // 1: zero-wait write, lane 3
    start_wr(32'h0000_0013, 8'hA5, 0, 0, 0, 0);
    wait_idle(50);
    chk("t1_latency", ack_at - t0, 3);
    chk("t1_acks", ack_cnt - b_ack, 1);
    chk("t1_awaddr", last_awaddr, 32'h10);
    chk("t1_wdata", last_wdata, 32'hA5A5_A5A5);
    chk("t1_wstrb", last_wstrb, 4'b1000);

    // 2: zero-wait read, lane 1
    s_rdata = 32'h1122_3344;
    start_rd(32'h0000_0021);
    wait_idle(50);
    chk("t2_acks", ack_cnt - b_ack, 1);
    chk("t2_araddr", last_araddr, 32'h20);
    chk("t2_rd", last_rd, 8'h33);

    // every lane, read and write
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'hC3D2_E1F0 ^ (32'h0101_0101 * i);
      start_rd(32'h50 + i);
      wait_idle(50);
      chk("lane_rd_acks", ack_cnt - b_ack, 1);
      start_wr(32'h60 + i, 8'h3C + 8'(i), 0, 0, 0, 0);
      wait_idle(50);
      chk("lane_wr_acks", ack_cnt - b_ack, 1);
    end
    chk("rd_held_over_wr", rbcp_rd, exp_rd);

    // 3: awready three cycles late
    aw_dly = 3;
    start_wr(32'h104, 8'h5C, 0, 0, 0, 0);
    wait_idle(50);
    aw_dly = 0;
    chk("t3_wvalid_cycles", w_cyc - b_wc, 1);
    chk("t3_awvalid_cycles", aw_cyc - b_awc, 4);
    chk("t3_acks", ack_cnt - b_ack, 1);

    // 4: second write while busy
    start_wr(32'h200, 8'h11, 0, 1, 32'h3FF, 8'hEE);
    wait_idle(50);
    chk("t4_drop", err_drop, 1);
    chk("t4_aw_count", aw_n - b_aw, 1);
    chk("t4_awaddr", last_awaddr, 32'h200);
    chk("t4_wdata", last_wdata, 32'h1111_1111);
    chk("t4_acks", ack_cnt - b_ack, 1);
    pulse_clr();
    chk("t4_clr", err_drop, 0);

    // we and re together in idle: write wins, drop flagged
    start_wr(32'h302, 8'h7E, 1, 0, 0, 0);
    wait_idle(50);
    chk("both_drop", err_drop, 1);
    chk("both_acks", ack_cnt - b_ack, 1);
    chk("both_wstrb", last_wstrb, 4'b0100);
    pulse_clr();

    // 5a: response one cycle inside the limit still acks
    r_dly = TO - 1; s_rdata = 32'hDEAD_BEEF;
    start_rd(32'h33);
    wait_idle(100);
    chk("edge_acks", ack_cnt - b_ack, 1);
    chk("edge_timeout", err_timeout, 0);

    // 5b: response at cycle 40 with SLVERR
    r_dly = 40; s_rresp = 2'b10;
    start_rd(32'h30);
    wait_idle(200);
    chk("t5_acks", ack_cnt - b_ack, 0);
    chk("t5_timeout", err_timeout, 1);
    chk("t5_resp", err_resp, 1);
    chk("t5_idle", busy, 0);
    r_dly = 0; s_rresp = 2'b00; s_rdata = 32'h8899_AABB;
    start_rd(32'h22);
    wait_idle(50);
    chk("t5_next_acks", ack_cnt - b_ack, 1);
    chk("t5_next_rd", last_rd, 8'h99);

    // 6: async reset while in RD_RESP
    r_dly = 10;
    start_rd(32'h40);
    for (int n = 0; n < 20 && !m_axi_rready; n++) begin @(negedge clk); #1; end
    chk("t6_in_rresp", m_axi_rready, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("t6_ack_busy", {rbcp_ack, busy}, 0);
    chk("t6_errs", {err_drop, err_timeout, err_resp}, 0);
    chk("t6_rd", rbcp_rd, 0);
    @(negedge clk); #1; rst = 1'b0;
    r_dly = 0; s_rdata = 32'h0F1E_2D3C;
    start_rd(32'h47);
    wait_idle(50);
    chk("t6_recover_acks", ack_cnt - b_ack, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
